// File: rtl/regfile_wb_ctrl.sv
// Register-file writeback arbiter: ALU and load results share a 4-entry FIFO that drains one write per cycle.
// Optional read-after-write bypass of pending writes is enabled with `define WB_BYPASS_EN.
module regfile_wb_ctrl #(
  parameter int N = 8,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         alu_valid,
  input  logic [M-1:0] alu_addr,
  input  logic [N-1:0] alu_data,
  output logic         alu_ready,
  input  logic         mem_valid,
  input  logic [M-1:0] mem_addr,
  input  logic [N-1:0] mem_data,
  output logic         mem_ready,
  output logic         we,
  output logic [M-1:0] wa3,
  output logic [N-1:0] wd3,
  input  logic [M-1:0] a1,
  input  logic [M-1:0] a2,
  output logic         fwd1_hit,
  output logic         fwd2_hit,
  output logic [N-1:0] fwd1_data,
  output logic [N-1:0] fwd2_data,
  output logic         busy
);
  typedef struct packed {
    logic [M-1:0] addr;
    logic [N-1:0] data;
  } wb_ent_t;

  wb_ent_t [3:0] fifo;
  logic [2:0]    count;
  logic [1:0]    rptr, wptr;
  logic          acc_alu, acc_mem, pop;
  logic [2:0]    npush;

  // Readiness comes from the registered count only; during reset the queue is empty by definition.
  assign alu_ready = !rst_n || (count < 3'd4);
  assign mem_ready = !rst_n || (alu_valid ? (count < 3'd3) : (count < 3'd4));
  assign acc_alu   = rst_n && alu_valid && alu_ready;
  assign acc_mem   = rst_n && mem_valid && mem_ready;
  assign pop       = (count != 3'd0);
  assign npush     = {2'b00, acc_alu} + {2'b00, acc_mem};
  assign busy      = (count != 3'd0) || we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
      we    <= 1'b0;
      wa3   <= '0;
      wd3   <= '0;
    end else begin
      we <= pop;
      if (pop) begin
        wa3  <= fifo[rptr].addr;
        wd3  <= fifo[rptr].data;
        rptr <= rptr + 2'd1;
      end
      wptr  <= wptr + npush[1:0];
      count <= count + npush - {2'b00, pop};
    end
  end

  // Storage needs no reset: entries are only observed through count/pointers.
  always_ff @(posedge clk) begin
    if (acc_alu) fifo[wptr] <= '{addr: alu_addr, data: alu_data};
    if (acc_mem) fifo[acc_alu ? wptr + 2'd1 : wptr] <= '{addr: mem_addr, data: mem_data};
  end

`ifdef WB_BYPASS_EN
  logic [1:0][M-1:0] ra;
  logic [1:0]        hit;
  logic [1:0][N-1:0] fd;

  assign ra = {a2, a1};

  // Scan oldest to youngest so the last match wins: driven write, then FIFO head to tail.
  always_comb begin
    hit = '0;
    fd  = '0;
    for (int k = 0; k < 2; k++) begin
      if (we && wa3 == ra[k]) begin
        hit[k] = 1'b1;
        fd[k]  = wd3;
      end
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < count && fifo[rptr + 2'(i)].addr == ra[k]) begin
          hit[k] = 1'b1;
          fd[k]  = fifo[rptr + 2'(i)].data;
        end
      end
    end
  end

  assign fwd1_hit  = hit[0];
  assign fwd2_hit  = hit[1];
  assign fwd1_data = fd[0];
  assign fwd2_data = fd[1];
`else
  logic unused_rd;
  assign unused_rd = ^{a1, a2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized + directed bench for regfile_wb_ctrl: queue-based reference model and a write-order scoreboard.
module tb_regfile_wb_ctrl;
  localparam int N = 8;
  localparam int M = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         alu_valid = 1'b0, mem_valid = 1'b0;
  logic [M-1:0] alu_addr = '0, mem_addr = '0, a1 = '0, a2 = '0;
  logic [N-1:0] alu_data = '0, mem_data = '0;
  logic         alu_ready, mem_ready, we, fwd1_hit, fwd2_hit, busy;
  logic [M-1:0] wa3;
  logic [N-1:0] wd3, fwd1_data, fwd2_data;

  regfile_wb_ctrl #(.N(N), .M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .we(we), .wa3(wa3), .wd3(wd3), .a1(a1), .a2(a2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M-1:0] a;
    logic [N-1:0] d;
  } ent_t;

  ent_t         q[$];   // pending writes not yet on the write port
  ent_t         sb[$];  // expected write order, consumed by the monitor
  ent_t         drv;
  bit           drv_v = 1'b0;
  bit           armed = 1'b0;
  logic [M-1:0] ra1 = '0, ra2 = '0;
  int           checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void fwd_exp(input logic [M-1:0] a, output bit h, output logic [N-1:0] d);
    h = 1'b0;
    d = '0;
    if (drv_v && drv.a == a) begin h = 1'b1; d = drv.d; end
    foreach (q[i]) if (q[i].a == a) begin h = 1'b1; d = q[i].d; end
  endfunction

  // Monitor: every write pulse must match the next expected entry.
  always @(negedge clk) begin
    if (armed && we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_we", {wa3, wd3}, 32'hFFFF_FFFF);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("wr_order", {22'd0, wa3, wd3}, {22'd0, e.a, e.d});
      end
    end
  end

  task automatic step(input bit rst, input bit av, input logic [M-1:0] aa, input logic [N-1:0] ad,
                      input bit mv, input logic [M-1:0] ma, input logic [N-1:0] md);
    bit           era, erm, h;
    logic [N-1:0] d;
    rst_n = !rst; alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md; a1 = ra1; a2 = ra2;
    @(negedge clk);
    era = rst ? 1'b1 : (q.size() < 4);
    erm = rst ? 1'b1 : (av ? (q.size() < 3) : (q.size() < 4));
    chk("alu_ready", alu_ready, era);
    chk("mem_ready", mem_ready, erm);
    if (armed) begin
      chk("we", we, drv_v);
      if (drv_v) chk("wa3_wd3", {wa3, wd3}, {drv.a, drv.d});
      chk("busy", busy, (q.size() > 0) || drv_v);
`ifdef WB_BYPASS_EN
      fwd_exp(ra1, h, d);
      chk("fwd1", {fwd1_hit, fwd1_data}, {h, d});
      fwd_exp(ra2, h, d);
      chk("fwd2", {fwd2_hit, fwd2_data}, {h, d});
`else
      h = 1'b0; d = '0;
      chk("fwd_off", {fwd1_hit, fwd2_hit, fwd1_data, fwd2_data}, {h, h, d, d});
`endif
    end
    @(posedge clk);
    if (rst) begin
      q.delete(); sb.delete(); drv_v = 1'b0; armed = 1'b1;
    end else begin
      if (q.size() > 0) begin drv = q.pop_front(); drv_v = 1'b1; end
      else drv_v = 1'b0;
      if (av && era) begin q.push_back('{aa, ad}); sb.push_back('{aa, ad}); end
      if (mv && erm) begin q.push_back('{ma, md}); sb.push_back('{ma, md}); end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    step(1'b1, 1'b1, 2'd1, 8'hEE, 1'b1, 2'd2, 8'hDD);  // requests under reset are dropped
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    idle(2);
    // Single write: one pulse, one cycle after acceptance
    step(1'b0, 1'b1, 2'd2, 8'h5A, 1'b0, '0, '0);
    idle(3);
    // Dual push: ALU before load
    step(1'b0, 1'b1, 2'd1, 8'h11, 1'b1, 2'd3, 8'h33);
    idle(4);
    // Backpressure
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 2'(i), 8'(8'h40 + i), 1'b1, 2'(i + 1), 8'(8'h80 + i));
    idle(6);
    // Bypass: youngest of two writes to the same address wins
    ra1 = 2'd2; ra2 = 2'd0;
    step(1'b0, 1'b1, 2'd2, 8'h10, 1'b0, '0, '0);
    step(1'b0, 1'b1, 2'd2, 8'h20, 1'b0, '0, '0);
    idle(3);
    // Reset with three entries queued
    step(1'b0, 1'b1, 2'd0, 8'hA0, 1'b1, 2'd1, 8'hA1);
    step(1'b0, 1'b1, 2'd2, 8'hA2, 1'b1, 2'd3, 8'hA3);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    chk("rst_wa3_wd3", {wa3, wd3}, 32'd0);
    idle(4);
    // Pointer wrap
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2'(i), 8'(i), 1'b0, '0, '0);
    idle(3);
    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      ra1 = 2'($urandom); ra2 = 2'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, 2'($urandom), 8'($urandom),
           $urandom_range(0, 9) < 6, 2'($urandom), 8'($urandom));
    end
    idle(8);
    chk("sb_drained", sb.size(), 32'd0);
    chk("busy_final", busy, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
